// File: rtl/nbit_piso_serializer.sv
// Parallel-in, serial-out shifter: accepts an N-bit word on a load handshake
// and emits it one bit per accepted serial beat, LSB or MSB first.
module nbit_piso_serializer #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         last,
  output logic         busy
);

  // Handshakes: a transfer happens on any cycle where valid & ready are both
  // high; the sender holds its payload stable while valid=1 and ready=0.
  // The load side may complete on the same cycle as the final serial beat.

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic at_last;
  logic beat;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    at_last    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    beat       = (state_q == SHIFT) && ser_ready;
    load_ready = (state_q == IDLE) || (at_last && ser_ready);
    ser_valid  = (state_q == SHIFT);
    busy       = (state_q == SHIFT);
    last       = at_last;
    ser_out    = 1'b0;
    if (state_q == SHIFT) begin
      ser_out = LSB_FIRST ? shreg_q[0] : shreg_q[N-1];
    end

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (LSB_FIRST) begin
            shreg_d = {1'b0, shreg_q[N-1:1]};
          end else begin
            shreg_d = {shreg_q[N-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          // Final beat: either chain straight into the next word or drain.
          if (at_last) begin
            cnt_d = '0;
            if (load_valid) begin
              shreg_d = din;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nbit_piso_serializer.sv
// Directed bench for nbit_piso_serializer: one LSB-first and one MSB-first
// instance, each scenario in its own task with hand-computed bit sequences.
module tb_nbit_piso_serializer;

  logic       clk;
  logic       rst_n;

  logic [7:0] din_l;
  logic       lv_l, lr_l, so_l, sv_l, sr_l, last_l, busy_l;
  logic [7:0] din_m;
  logic       lv_m, lr_m, so_m, sv_m, sr_m, last_m, busy_m;

  int tests_run;
  int tests_failed;

  nbit_piso_serializer #(.N(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din_l), .load_valid(lv_l), .load_ready(lr_l),
    .ser_out(so_l), .ser_valid(sv_l), .ser_ready(sr_l), .last(last_l), .busy(busy_l)
  );

  nbit_piso_serializer #(.N(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din_m), .load_valid(lv_m), .load_ready(lr_m),
    .ser_out(so_m), .ser_valid(sv_m), .ser_ready(sr_m), .last(last_m), .busy(busy_m)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are checked 1ns later.
  task automatic test_reset();
    rst_n = 1'b0;
    din_l = '0; lv_l = 1'b0; sr_l = 1'b1;
    din_m = '0; lv_m = 1'b0; sr_m = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({sv_l, busy_l, so_l, last_l} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_hold: got sv/busy/out/last=%b required 0000", {sv_l, busy_l, so_l, last_l});
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({lr_l, sv_l, busy_l, so_l, last_l} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_release_lsb: got lr/sv/busy/out/last=%b required 10000", {lr_l, sv_l, busy_l, so_l, last_l});
    end
    tests_run++;
    if ({lr_m, sv_m, busy_m, so_m, last_m} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_release_msb: got lr/sv/busy/out/last=%b required 10000", {lr_m, sv_m, busy_m, so_m, last_m});
    end
  endtask

  task automatic test_lsb_single();
    logic [0:7] seq;
    seq = 8'b1010_0101;
    @(negedge clk);
    din_l = 8'hA5; lv_l = 1'b1; sr_l = 1'b1;
    #1;
    tests_run++;
    if (lr_l !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_load_ready: got %b required 1", lr_l);
    end
    @(negedge clk);
    lv_l = 1'b0; din_l = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests_run++;
      if ({sv_l, so_l, last_l} !== {1'b1, seq[i], (i == 7)}) begin
        tests_failed++;
        $display("FAIL single_beat%0d: got sv/out/last=%b required %b", i, {sv_l, so_l, last_l}, {1'b1, seq[i], (i == 7)});
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if ({sv_l, busy_l, lr_l} !== 3'b001) begin
      tests_failed++;
      $display("FAIL single_idle: got sv/busy/lr=%b required 001", {sv_l, busy_l, lr_l});
    end
  endtask

  task automatic test_msb_stall();
    logic [0:7] seq;
    int         valid_cycles;
    seq = 8'b1100_0011;
    valid_cycles = 0;
    @(negedge clk);
    din_m = 8'hC3; lv_m = 1'b1; sr_m = 1'b1;
    @(negedge clk);
    lv_m = 1'b0; din_m = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (b == 2 || b == 3) begin
        for (int s = 0; s < 2; s++) begin
          sr_m = 1'b0;
          #1;
          if (sv_m) valid_cycles++;
          tests_run++;
          if ({sv_m, so_m, last_m, lr_m} !== {1'b1, seq[b], 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL msb_stall_b%0d_s%0d: got sv/out/last/lr=%b required %b", b, s, {sv_m, so_m, last_m, lr_m}, {1'b1, seq[b], 2'b00});
          end
          @(negedge clk);
        end
      end
      sr_m = 1'b1;
      #1;
      if (sv_m) valid_cycles++;
      tests_run++;
      if ({sv_m, so_m, last_m} !== {1'b1, seq[b], (b == 7)}) begin
        tests_failed++;
        $display("FAIL msb_beat%0d: got sv/out/last=%b required %b", b, {sv_m, so_m, last_m}, {1'b1, seq[b], (b == 7)});
      end
      @(negedge clk);
    end
    #1;
    if (sv_m) valid_cycles++;
    tests_run++;
    if (valid_cycles !== 12) begin
      tests_failed++;
      $display("FAIL msb_valid_cycles: got %0d required 12", valid_cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:15] seq;
    seq = 16'b1111_0000_0000_1111;
    @(negedge clk);
    din_l = 8'h0F; lv_l = 1'b1; sr_l = 1'b1;
    @(negedge clk);
    lv_l = 1'b0; din_l = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        lv_l = 1'b1; din_l = 8'hF0;
      end else begin
        lv_l = 1'b0; din_l = 8'h00;
      end
      #1;
      tests_run++;
      if ({sv_l, so_l, last_l, lr_l} !== {1'b1, seq[i], (i == 7 || i == 15), (i == 7 || i == 15)}) begin
        tests_failed++;
        $display("FAIL b2b_beat%0d: got sv/out/last/lr=%b required %b", i, {sv_l, so_l, last_l, lr_l},
                 {1'b1, seq[i], (i == 7 || i == 15), (i == 7 || i == 15)});
      end
      @(negedge clk);
    end
    lv_l = 1'b0;
    #1;
    tests_run++;
    if (sv_l !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got sv=%b required 0", sv_l);
    end
  endtask

  task automatic test_reset_midword();
    logic [0:7] seq;
    seq = 8'b1000_0000;
    @(negedge clk);
    din_l = 8'hFF; lv_l = 1'b1; sr_l = 1'b1;
    @(negedge clk);
    lv_l = 1'b0; din_l = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({sv_l, busy_l, so_l, last_l} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midreset_immediate: got sv/busy/out/last=%b required 0000", {sv_l, busy_l, so_l, last_l});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({lr_l, sv_l} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midreset_release: got lr/sv=%b required 10", {lr_l, sv_l});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (sv_l !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_no_beats: got sv=%b required 0", sv_l);
    end
    @(negedge clk);
    din_l = 8'h01; lv_l = 1'b1;
    @(negedge clk);
    lv_l = 1'b0; din_l = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests_run++;
      if ({sv_l, so_l, last_l} !== {1'b1, seq[i], (i == 7)}) begin
        tests_failed++;
        $display("FAIL midreset_word_beat%0d: got sv/out/last=%b required %b", i, {sv_l, so_l, last_l}, {1'b1, seq[i], (i == 7)});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_load();
    logic [0:7] seq;
    seq = 8'b0101_0101;
    @(negedge clk);
    din_l = 8'hAA; lv_l = 1'b1; sr_l = 1'b1;
    @(negedge clk);
    lv_l = 1'b0; din_l = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        lv_l = 1'b1; din_l = 8'h55;
      end else begin
        lv_l = 1'b0; din_l = 8'h00;
      end
      #1;
      tests_run++;
      if ({sv_l, so_l, last_l, lr_l} !== {1'b1, seq[i], (i == 7), (i == 7)}) begin
        tests_failed++;
        $display("FAIL ignored_beat%0d: got sv/out/last/lr=%b required %b", i, {sv_l, so_l, last_l, lr_l}, {1'b1, seq[i], (i == 7), (i == 7)});
      end
      @(negedge clk);
    end
    lv_l = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if ({sv_l, busy_l} !== 2'b00) begin
        tests_failed++;
        $display("FAIL ignored_idle%0d: got sv/busy=%b required 00", i, {sv_l, busy_l});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_lsb_single();
    test_msb_stall();
    test_back_to_back();
    test_reset_midword();
    test_ignored_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
